// File: rtl/alu_share_ctrl_if.sv
// Requester/response bus for alu_share_ctrl: two operation request ports and one tagged response port.
// Every channel is valid/ready: a transfer happens on the rising edge where valid and ready are both 1;
// the sender holds its payload steady while valid is high and the receiver may hold ready low indefinitely.
interface alu_share_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one external ALU between two requesters; one operation in flight at a time,
// result returned on a tagged response port. Illegal opcodes are replaced by a harmless AND of zeros.
module alu_share_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_share_ctrl_if.slave  bus,
  output logic [WIDTH-1:0] alu_ain,
  output logic [WIDTH-1:0] alu_bin,
  output logic [2:0]       alu_choose,
  input  logic [WIDTH-1:0] alu_cout,
  input  logic             alu_zero,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last;
  logic             w_gnt;
  logic             w_gnt_id;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_illegal;
  logic [WIDTH-1:0] r_ain;
  logic [WIDTH-1:0] r_bin;
  logic [2:0]       r_choose;
  logic             r_err;
  logic             r_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zero;
  logic             r_rsp_err;
  logic             r_rsp_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Granting in IDLE is also the handshake: ready only ever rises for a requester that is valid.
  always_comb begin
    w_next_state = r_state;
    w_gnt        = 1'b0;
    w_gnt_id     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          w_gnt        = 1'b1;
          w_gnt_id     = (bus.req0_valid && bus.req1_valid) ? ~r_last : bus.req1_valid;
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: w_next_state = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_op      = w_gnt_id ? bus.req1_op : bus.req0_op;
  assign w_a       = w_gnt_id ? bus.req1_a  : bus.req0_a;
  assign w_b       = w_gnt_id ? bus.req1_b  : bus.req0_b;
  // 011, 101 and 111 are the codes the ALU does not decode.
  assign w_illegal = w_op[0] & (w_op[1] | w_op[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= 1'b1;
      r_ain      <= '0;
      r_bin      <= '0;
      r_choose   <= 3'b010;
      r_err      <= 1'b0;
      r_id       <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_rsp_id   <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_last   <= w_gnt_id;
        r_id     <= w_gnt_id;
        r_err    <= w_illegal;
        r_ain    <= w_illegal ? '0 : w_a;
        r_bin    <= w_illegal ? '0 : w_b;
        r_choose <= w_illegal ? 3'b000 : w_op;
      end
      if (r_state == S_EXEC) begin
        r_rsp_data <= r_err ? '0 : alu_cout;
        r_rsp_zero <= r_err ? 1'b1 : alu_zero;
        r_rsp_err  <= r_err;
        r_rsp_id   <= r_id;
      end
    end
  end

  assign bus.req0_ready = w_gnt & ~w_gnt_id;
  assign bus.req1_ready = w_gnt &  w_gnt_id;
  assign bus.rsp_valid  = (r_state == S_RESP);
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.rsp_err    = r_rsp_err;
  assign alu_ain        = r_ain;
  assign alu_bin        = r_bin;
  assign alu_choose     = r_choose;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU on the ALU port, directed scenarios plus a random pass,
// responses checked against an expected queue of {id, err, zero, data}.
module tb_alu_share_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] alu_ain;
  logic [W-1:0] alu_bin;
  logic [W-1:0] alu_cout;
  logic [2:0]   alu_choose;
  logic         alu_zero;
  logic [1:0]   dbg_state;
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  logic [W+2:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_ctrl_if #(.WIDTH(W)) bus();

  alu_share_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .alu_ain     (alu_ain),
    .alu_bin     (alu_bin),
    .alu_choose  (alu_choose),
    .alu_cout    (alu_cout),
    .alu_zero    (alu_zero),
    .o_dbg_state (dbg_state)
  );

  // Combinational ALU; slt is an unsigned compare.
  always_comb begin
    case (alu_choose)
      3'b010:  alu_cout = alu_ain + alu_bin;
      3'b110:  alu_cout = alu_ain - alu_bin;
      3'b000:  alu_cout = alu_ain & alu_bin;
      3'b001:  alu_cout = alu_ain | alu_bin;
      3'b100:  alu_cout = (alu_ain < alu_bin) ? 32'd1 : 32'd0;
      default: alu_cout = '0;
    endcase
  end
  assign alu_zero = (alu_cout == '0);

  function automatic logic [W+2:0] exp_of(input bit id, input logic [2:0] op,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    if (op == 3'b011 || op == 3'b101 || op == 3'b111) return {id, 1'b1, 1'b1, {W{1'b0}}};
    case (op)
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      default: r = (a < b) ? 32'd1 : 32'd0;
    endcase
    return {id, 1'b0, (r == '0), r};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_req(input bit id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 1'b0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
    #1;
  endtask

  task automatic idle_reqs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
  endtask

  // Drive one request while IDLE, let it be taken at the next edge, then drop valid.
  task automatic issue(input bit id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    drive_req(id, op, a, b);
    tick();
    idle_reqs();
  endtask

  task automatic wait_grant(output bit id, output bit ok);
    int n = 0;
    while (!(bus.req0_ready || bus.req1_ready) && n < 20) begin
      tick();
      n++;
    end
    ok = bus.req0_ready ^ bus.req1_ready;
    id = bus.req1_ready;
  endtask

  task automatic get_rsp(output logic [W+2:0] obs, output bit ok);
    int n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    ok  = (bus.rsp_valid === 1'b1);
    obs = {bus.rsp_id, bus.rsp_err, bus.rsp_zero, bus.rsp_data};
  endtask

  task automatic test_reset();
    total++;
    if ({dbg_state, alu_choose, alu_ain, alu_bin} !== {2'd0, 3'b010, 64'd0}) begin
      bad++;
      $display("FAIL reset_alu: got state=%0d choose=%b ain=%h bin=%h want 0/010/0/0", dbg_state, alu_choose, alu_ain, alu_bin);
    end
    total++;
    if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready, bus.rsp_id, bus.rsp_err, bus.rsp_zero, bus.rsp_data} !== 38'd0) begin
      bad++;
      $display("FAIL reset_rsp: got valid=%b rdy=%b%b id=%b err=%b zero=%b data=%h want all 0", bus.rsp_valid,
               bus.req0_ready, bus.req1_ready, bus.rsp_id, bus.rsp_err, bus.rsp_zero, bus.rsp_data);
    end
  endtask

  task automatic test_single_add();
    logic [W+2:0] obs, exp;
    bus.rsp_ready = 1'b1;
    drive_req(1'b0, 3'b010, 32'd5, 32'd7);
    exp_q.push_back({1'b0, 1'b0, 1'b0, 32'd12});
    total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      bad++; $display("FAIL add_ready: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    tick();
    idle_reqs();
    total++;
    if ({bus.req0_ready, bus.rsp_valid, dbg_state, alu_ain, alu_bin, alu_choose} !== {2'b00, 2'd1, 32'd5, 32'd7, 3'b010}) begin
      bad++;
      $display("FAIL add_exec: got rdy=%b vld=%b st=%0d ain=%h bin=%h ch=%b want 0/0/1/5/7/010", bus.req0_ready,
               bus.rsp_valid, dbg_state, alu_ain, alu_bin, alu_choose);
    end
    tick();
    obs = {bus.rsp_id, bus.rsp_err, bus.rsp_zero, bus.rsp_data};
    exp = exp_q.pop_front();
    total++;
    if (bus.rsp_valid !== 1'b1 || obs !== exp) begin
      bad++; $display("FAIL add_rsp: got vld=%b rsp=%h want vld=1 rsp=%h", bus.rsp_valid, obs, exp);
    end
    tick();
    total++;
    if (bus.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL add_rsp_drop: got vld=%b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_illegal();
    logic [W+2:0] obs, exp;
    bit ok;
    bus.rsp_ready = 1'b1;
    drive_req(1'b1, 3'b111, 32'h1234, 32'h55);
    exp_q.push_back({1'b1, 1'b1, 1'b1, 32'd0});
    tick();
    idle_reqs();
    total++;
    if ({alu_choose, alu_ain, alu_bin} !== {3'b000, 64'd0}) begin
      bad++; $display("FAIL illegal_alu: got ch=%b ain=%h bin=%h want 000/0/0", alu_choose, alu_ain, alu_bin);
    end
    get_rsp(obs, ok);
    exp = exp_q.pop_front();
    total++;
    if (!ok || obs !== exp) begin
      bad++; $display("FAIL illegal_rsp: got ok=%b rsp=%h want %h", ok, obs, exp);
    end
    tick();
    exp_q.push_back({1'b1, 1'b0, 1'b0, 32'd3});
    issue(1'b1, 3'b010, 32'd1, 32'd2);
    get_rsp(obs, ok);
    exp = exp_q.pop_front();
    total++;
    if (!ok || obs !== exp) begin
      bad++; $display("FAIL legal_after_illegal: got ok=%b rsp=%h want %h", ok, obs, exp);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [W+2:0] obs, exp;
    bit ok, id, exp_id;
    int last_cyc = 0;
    bus.rsp_ready = 1'b1;
    drive_req(1'b0, 3'b110, 32'd9, 32'd9);
    drive_req(1'b1, 3'b001, 32'h0F, 32'hF0);
    exp_id = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_grant(id, ok);
      total++;
      if (!ok || id !== exp_id) begin
        bad++; $display("FAIL rr_grant%0d: got ok=%b id=%b want id=%b", i, ok, id, exp_id);
      end
      if (i > 0) begin
        total++;
        if (cyc - last_cyc != 3) begin
          bad++; $display("FAIL rr_interval%0d: got %0d cycles want 3", i, cyc - last_cyc);
        end
      end
      last_cyc = cyc;
      exp_q.push_back(exp_id ? {1'b1, 1'b0, 1'b0, 32'hFF} : {1'b0, 1'b0, 1'b1, 32'd0});
      exp_id = ~exp_id;
      tick();
      get_rsp(obs, ok);
      if (i == 3) idle_reqs();
      exp = exp_q.pop_front();
      total++;
      if (!ok || obs !== exp) begin
        bad++; $display("FAIL rr_rsp%0d: got ok=%b rsp=%h want %h", i, ok, obs, exp);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [W+2:0] obs, exp, snap;
    bit ok, id;
    bus.rsp_ready = 1'b0;
    drive_req(1'b0, 3'b010, 32'h10, 32'h20);
    drive_req(1'b1, 3'b010, 32'h100, 32'h1);
    wait_grant(id, ok);
    total++;
    if (!ok || id !== 1'b0) begin
      bad++; $display("FAIL stall_grant: got ok=%b id=%b want id=0", ok, id);
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, 32'h30});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 32'h101});
    tick();
    get_rsp(obs, ok);
    exp = exp_q.pop_front();
    total++;
    if (!ok || obs !== exp) begin
      bad++; $display("FAIL stall_rsp0: got ok=%b rsp=%h want %h", ok, obs, exp);
    end
    snap = obs;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready, bus.rsp_id, bus.rsp_err, bus.rsp_zero, bus.rsp_data}
          !== {3'b100, snap}) begin
        bad++;
        $display("FAIL stall_hold%0d: got vld=%b rdy=%b%b rsp=%h want 1/00/%h", i, bus.rsp_valid,
                 bus.req0_ready, bus.req1_ready, {bus.rsp_id, bus.rsp_err, bus.rsp_zero, bus.rsp_data}, snap);
      end
    end
    bus.rsp_ready = 1'b1;
    #1;
    tick();
    total++;
    if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 3'b001) begin
      bad++; $display("FAIL stall_release: got vld=%b rdy=%b%b want 0/01", bus.rsp_valid, bus.req0_ready, bus.req1_ready);
    end
    tick();
    idle_reqs();
    get_rsp(obs, ok);
    exp = exp_q.pop_front();
    total++;
    if (!ok || obs !== exp) begin
      bad++; $display("FAIL stall_rsp1: got ok=%b rsp=%h want %h", ok, obs, exp);
    end
    tick();
  endtask

  task automatic test_slt();
    logic [W+2:0] obs, exp;
    bit ok;
    bus.rsp_ready = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 1'b0, 32'd1});
    issue(1'b0, 3'b100, 32'd3, 32'hFFFF_FFFF);
    get_rsp(obs, ok);
    exp = exp_q.pop_front();
    total++;
    if (!ok || obs !== exp) begin
      bad++; $display("FAIL slt_lt: got ok=%b rsp=%h want %h", ok, obs, exp);
    end
    tick();
    exp_q.push_back({1'b0, 1'b0, 1'b1, 32'd0});
    issue(1'b0, 3'b100, 32'd8, 32'd2);
    get_rsp(obs, ok);
    exp = exp_q.pop_front();
    total++;
    if (!ok || obs !== exp) begin
      bad++; $display("FAIL slt_ge: got ok=%b rsp=%h want %h", ok, obs, exp);
    end
    tick();
  endtask

  task automatic test_reset_in_exec();
    logic [W+2:0] obs, exp;
    bit ok;
    bus.rsp_ready = 1'b1;
    issue(1'b0, 3'b010, 32'h11, 32'h22);
    rst_n = 1'b0;
    #1;
    total++;
    if ({dbg_state, alu_choose, alu_ain, alu_bin, bus.rsp_valid, bus.rsp_data} !== {2'd0, 3'b010, 65'd0, 32'd0}) begin
      bad++;
      $display("FAIL rst_exec: got st=%0d ch=%b ain=%h bin=%h vld=%b data=%h want 0/010/0/0/0/0", dbg_state,
               alu_choose, alu_ain, alu_bin, bus.rsp_valid, bus.rsp_data);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.rsp_valid !== 1'b0) begin
        bad++; $display("FAIL rst_no_rsp%0d: got vld=%b want 0", i, bus.rsp_valid);
      end
    end
    rst_n = 1'b1;
    tick();
    drive_req(1'b0, 3'b010, 32'd2, 32'd2);
    drive_req(1'b1, 3'b010, 32'd3, 32'd3);
    total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      bad++; $display("FAIL rst_rr_first: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, 32'd4});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 32'd6});
    tick();
    get_rsp(obs, ok);
    exp = exp_q.pop_front();
    total++;
    if (!ok || obs !== exp) begin
      bad++; $display("FAIL rst_rsp0: got ok=%b rsp=%h want %h", ok, obs, exp);
    end
    tick();
    tick();
    get_rsp(obs, ok);
    idle_reqs();
    exp = exp_q.pop_front();
    total++;
    if (!ok || obs !== exp) begin
      bad++; $display("FAIL rst_rsp1: got ok=%b rsp=%h want %h", ok, obs, exp);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W+2:0] obs, exp;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    bit           ok, id;
    for (int i = 0; i < 12; i++) begin
      id = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      bus.rsp_ready = 1'($urandom_range(0, 1));
      exp_q.push_back(exp_of(id, op, a, b));
      issue(id, op, a, b);
      get_rsp(obs, ok);
      if (bus.rsp_ready == 1'b0) begin
        repeat ($urandom_range(1, 3)) tick();
        bus.rsp_ready = 1'b1;
        #1;
      end
      exp = exp_q.pop_front();
      total++;
      if (!ok || obs !== exp) begin
        bad++; $display("FAIL rand%0d op=%b a=%h b=%h: got ok=%b rsp=%h want %h", i, op, a, b, ok, obs, exp);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_op = 3'b000; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 3'b000; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_single_add();
    test_illegal();
    test_round_robin();
    test_stall();
    test_slt();
    test_reset_in_exec();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL queue_empty: got %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
